// File: rtl/hsv_frame_streamer.sv
// hsv_frame_streamer: raster-scan source of packed {H,S,V} pixels.
// Reads frame memory one word per cycle, buffers returns in a small FIFO and
// emits one pixel per strobe with x/y/linear address.
// Build option: define TEST_PATTERN_EN to replace memory reads with an
// internal pattern (H=x[9:2], S=8'hFF, V=y[8:1]); mem_re then stays 0.
module hsv_frame_streamer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        hold,
  output logic        busy,
  output logic        mem_re,
  output logic [18:0] mem_addr,
  input  logic [23:0] mem_data,
  output logic        ntsc_we,
  output logic [18:0] ntsc_address,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic [7:0]  H,
  output logic [7:0]  S,
  output logic [7:0]  V,
  output logic        frame_done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [18:0] LAST_ADDR = 19'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [10:0] LAST_X    = 11'(H_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [18:0]  req_addr_q, req_addr_d;
  logic [23:0]  fifo_mem_q [FIFO_DEPTH];
  logic [23:0]  fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [10:0]  ex_q, ex_d;
  logic [9:0]   ey_q, ey_d;
  logic [18:0]  ea_q, ea_d;
  logic         ntsc_we_q, ntsc_we_d;
  logic [18:0]  ntsc_address_q, ntsc_address_d;
  logic [10:0]  x_q, x_d;
  logic [9:0]   y_q, y_d;
  logic [7:0]   h_q, h_d, s_q, s_d, v_q, v_d;

  logic         start_ok_s;
  logic         issue_s;
  logic         mem_re_s;
  logic         push_s;
  logic [23:0]  push_data_s;
  logic         pop_s;

  assign start_ok_s = (state_q == IDLE) && start;

`ifdef TEST_PATTERN_EN
  logic [10:0] rx_q, rx_d;
  logic [9:0]  ry_q, ry_d;

  // Pattern generator: one pixel per cycle whenever the FIFO has a free slot
  always_comb begin
    mem_re_s    = 1'b0;
    issue_s     = (state_q == RUN) && (fifo_cnt_q < CW'(FIFO_DEPTH));
    push_s      = issue_s;
    push_data_s = {rx_q[9:2], 8'hFF, ry_q[8:1]};
    rx_d        = rx_q;
    ry_d        = ry_q;
    if (start_ok_s) begin
      rx_d = 11'd0;
      ry_d = 10'd0;
    end else if (issue_s) begin
      if (rx_q == LAST_X) begin
        rx_d = 11'd0;
        ry_d = ry_q + 10'd1;
      end else begin
        rx_d = rx_q + 11'd1;
      end
    end else begin
      rx_d = rx_q;
    end
  end

  // Pattern raster position registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q <= 11'd0;
      ry_q <= 10'd0;
    end else begin
      rx_q <= rx_d;
      ry_q <= ry_d;
    end
  end
`else
  logic [MEM_LAT-1:0] vld_sr_q, vld_sr_d;
  int unsigned        in_flight_s;

  // Credit-based read issue and return tagging; returns land exactly MEM_LAT later
  always_comb begin
    in_flight_s = 0;
    for (int i = 0; i < MEM_LAT; i++) begin
      in_flight_s = in_flight_s + 32'(vld_sr_q[i]);
    end
    mem_re_s    = (state_q == RUN) &&
                  ((32'(fifo_cnt_q) + in_flight_s) < 32'(FIFO_DEPTH));
    issue_s     = mem_re_s;
    push_s      = vld_sr_q[MEM_LAT-1];
    push_data_s = mem_data;
    vld_sr_d    = '0;
    vld_sr_d[0] = mem_re_s;
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
  end

  // In-flight read tag shift register; cleared by reset so stale returns are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr_q <= '0;
    end else begin
      vld_sr_q <= vld_sr_d;
    end
  end
`endif

  // Frame FSM and request address counter
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          req_addr_d = 19'd0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (issue_s) begin
          req_addr_d = req_addr_q + 19'd1;
          if (req_addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (ntsc_we_q && (ntsc_address_q == LAST_ADDR)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Return FIFO bookkeeping, emit counters and next registered pixel outputs
  always_comb begin
    fifo_mem_d     = fifo_mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fifo_cnt_d     = fifo_cnt_q;
    ex_d           = ex_q;
    ey_d           = ey_q;
    ea_d           = ea_q;
    ntsc_address_d = ntsc_address_q;
    x_d            = x_q;
    y_d            = y_q;
    h_d            = h_q;
    s_d            = s_q;
    v_d            = v_q;
    pop_s          = (fifo_cnt_q != '0) && !hold;
    ntsc_we_d      = pop_s;

    if (push_s) begin
      fifo_mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (start_ok_s) begin
      ex_d = 11'd0;
      ey_d = 10'd0;
      ea_d = 19'd0;
    end else if (pop_s) begin
      x_d            = ex_q;
      y_d            = ey_q;
      ntsc_address_d = ea_q;
      {h_d, s_d, v_d} = fifo_mem_q[rd_ptr_q];
      ea_d           = ea_q + 19'd1;
      if (ex_q == LAST_X) begin
        ex_d = 11'd0;
        ey_d = ey_q + 10'd1;
      end else begin
        ex_d = ex_q + 11'd1;
      end
    end else begin
      ea_d = ea_q;
    end
  end

  // Core state: FSM, request counter, FIFO, emit counters, registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      req_addr_q     <= 19'd0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 24'd0;
      end
      ex_q           <= 11'd0;
      ey_q           <= 10'd0;
      ea_q           <= 19'd0;
      ntsc_we_q      <= 1'b0;
      ntsc_address_q <= 19'd0;
      x_q            <= 11'd0;
      y_q            <= 10'd0;
      h_q            <= 8'd0;
      s_q            <= 8'd0;
      v_q            <= 8'd0;
    end else begin
      state_q        <= state_d;
      req_addr_q     <= req_addr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      fifo_mem_q     <= fifo_mem_d;
      ex_q           <= ex_d;
      ey_q           <= ey_d;
      ea_q           <= ea_d;
      ntsc_we_q      <= ntsc_we_d;
      ntsc_address_q <= ntsc_address_d;
      x_q            <= x_d;
      y_q            <= y_d;
      h_q            <= h_d;
      s_q            <= s_d;
      v_q            <= v_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign frame_done   = (state_q == DONE);
  assign mem_re       = mem_re_s;
  assign mem_addr     = req_addr_q;
  assign ntsc_we      = ntsc_we_q;
  assign ntsc_address = ntsc_address_q;
  assign x            = x_q;
  assign y            = y_q;
  assign H            = h_q;
  assign S            = s_q;
  assign V            = v_q;

endmodule

// File: tb/tb_hsv_frame_streamer.sv
// Scoreboard bench for hsv_frame_streamer on a 4x2 frame, MEM_LAT=2.
`timescale 1ns/1ps
module tb_hsv_frame_streamer;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int ML = 2;
  localparam int FD = 4;
  localparam int NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        busy, mem_re, ntsc_we, frame_done;
  logic [18:0] mem_addr, ntsc_address;
  logic [23:0] mem_data;
  logic [10:0] x;
  logic [9:0]  y;
  logic [7:0]  H, S, V;

  hsv_frame_streamer #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .MEM_LAT(ML), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .hold(hold), .busy(busy),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
    .ntsc_we(ntsc_we), .ntsc_address(ntsc_address), .x(x), .y(y),
    .H(H), .S(S), .V(V), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame memory model: data = addr*3, valid exactly ML cycles after mem_re
  logic        pipe_v [ML];
  logic [18:0] pipe_a [ML];
  always @(posedge clk) begin
    pipe_v[0] <= mem_re;
    pipe_a[0] <= mem_addr;
    for (int i = 1; i < ML; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign mem_data = pipe_v[ML-1] ? (24'(pipe_a[ML-1]) * 24'd3) : 24'd0;

  typedef struct packed {
    logic [18:0] a;
    logic [10:0] px;
    logic [9:0]  py;
    logic [23:0] hsv;
  } pix_t;

  pix_t exp_q[$];
  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected pixels of one whole frame, queued when start is driven
  task automatic push_frame();
    for (int n = 0; n < NPIX; n++) begin
      pix_t p;
      p.a  = 19'(n);
      p.px = 11'(n % HA);
      p.py = 10'(n / HA);
`ifdef TEST_PATTERN_EN
      p.hsv = {p.px[9:2], 8'hFF, p.py[8:1]};
`else
      p.hsv = 24'(n * 3);
`endif
      exp_q.push_back(p);
    end
  endtask

  int   cyc = 0;
  int   strobe_cnt = 0, done_cnt = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
  int   fifo_max = 0;
  logic hold_prev = 1'b0;
  logic mem_re_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every strobe
  always @(negedge clk) begin : mon
    pix_t p;
    if (ntsc_we) begin
      check_eq("no_strobe_after_hold", 32'(hold_prev), 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        p = exp_q.pop_front();
        check_eq("pix_addr", 32'(ntsc_address), 32'(p.a));
        check_eq("pix_xy", {11'd0, x, y}, {11'd0, p.px, p.py});
        check_eq("pix_hsv", {8'd0, H, S, V}, {8'd0, p.hsv});
      end
      if (strobe_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      strobe_cnt++;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (int'(dut.fifo_cnt_q) > fifo_max) fifo_max = int'(dut.fifo_cnt_q);
    if (mem_re) mem_re_seen = 1'b1;
    hold_prev = hold;
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ctrl"}, {28'd0, ntsc_we, busy, mem_re, frame_done}, 32'd0);
    check_eq({tag, "_pos"}, {2'd0, ntsc_address, x}, 32'd0);
    check_eq({tag, "_y"}, 32'(y), 32'd0);
    check_eq({tag, "_hsv"}, {8'd0, H, S, V}, 32'd0);
    check_eq({tag, "_addr"}, 32'(mem_addr), 32'd0);
  endtask

  // mode 0: plain; 1: hold 1-of-3; 2: stray starts mid-frame and on frame_done;
  // 3: reset after the fifth pixel
  task automatic run_frame(input int mode);
    int start_cyc;
    int budget;
    bit done_start;
    exp_q.delete();
    push_frame();
    strobe_cnt = 0;
    done_cnt   = 0;
    fifo_max   = 0;
    done_start = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("busy_after_start", 32'(busy), 32'd1);
    budget = 0;
    while (done_cnt == 0 && budget < 200 && !(mode == 3 && strobe_cnt >= 5)) begin
      if (mode == 1) hold = (cyc % 3 == 0);
      if (mode == 2) begin
        start = 1'b0;
        if (strobe_cnt == 3) start = 1'b1;
        if (strobe_cnt == NPIX && !done_start) begin
          start      = 1'b1;
          done_start = 1'b1;
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    start = 1'b0;
    hold  = 1'b0;
    check_eq("timeout", 32'(budget >= 200), 32'd0);
    if (mode == 3) begin
      reset_n = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      exp_q.delete();
      repeat (12) @(posedge clk);
      #1;
      check_eq("no_done_after_reset", 32'(done_cnt), 32'd0);
      check_eq("idle_after_reset", 32'(busy), 32'd0);
      return;
    end
    check_eq("strobe_count", 32'(strobe_cnt), 32'(NPIX));
    check_eq("done_count", 32'(done_cnt), 32'd1);
    check_eq("done_after_last", 32'(done_cyc - last_cyc), 32'd1);
    check_eq("busy_low_after_done", 32'(busy), 32'd0);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check_eq("fifo_within_depth", 32'(fifo_max > FD), 32'd0);
    if (mode == 0) begin
`ifdef TEST_PATTERN_EN
      check_eq("first_latency", 32'(first_cyc - start_cyc), 32'd2);
`else
      check_eq("first_latency", 32'(first_cyc - start_cyc), 32'(ML + 2));
`endif
      check_eq("gap_free", 32'(last_cyc - first_cyc), 32'(NPIX - 1));
    end
    if (mode == 2) begin
      repeat (10) @(posedge clk);
      #1;
      check_eq("stray_start_no_frame", 32'(strobe_cnt), 32'(NPIX));
      check_eq("stray_start_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(0);
    run_frame(3);
    run_frame(0);
`ifdef TEST_PATTERN_EN
    check_eq("mem_re_never", 32'(mem_re_seen), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
